// File: rtl/store_pkg.sv
// Shared definitions for the store path: funct3 codes, the buffered entry
// type and the byte-enable helper. Entry fields are sized for the widest build.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_NB     = MAX_DATA_W / 8;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_NB-1:0]     be;
    } store_entry_t;

    // Enables across two adjacent words; the upper half covers a word-crossing store.
    function automatic logic [2*MAX_NB-1:0] store_be(input logic [3:0] size, input logic [2:0] lane);
        return ((16'd1 << size) - 16'd1) << lane;
    endfunction

endpackage

// File: rtl/store_if.sv
// Request and memory-side signals of the store unit. The store unit uses the
// master modport; the surrounding pipeline/memory model uses slave.
interface store_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [2:0]        req_funct3;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    modport master (
        input  req_valid, req_addr, req_data, req_funct3, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_addr, req_data, req_funct3, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_fifo.sv
// Generic DEPTH-entry synchronous FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module store_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  T            i_data,
    input  logic        i_pop,
    output T            o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [PW:0] o_count
);
    T            r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/store_unit.sv
// Store path from MEM stage to data memory: funct3 decode, lane steering,
// misalignment check and a buffered drain. Define STORE_SPLIT_MISALIGNED_EN
// to perform misaligned stores (word-crossing ones as two entries).
module store_unit
    import store_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    store_if.master       bus,
    output logic          misalign_fault,
    output logic [CW-1:0] count
);
    logic [LB-1:0]       w_lane;
    logic [3:0]          w_size;
    logic                w_legal;
    logic                w_misaligned;
    logic                w_accept;
    logic                w_enq;
    logic                w_fault_d;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_base;
    logic [2*DATA_W-1:0] w_shift;
    logic [2*NB-1:0]     w_be2;
    store_entry_t        w_lo;
    store_entry_t        w_push_entry;
    store_entry_t        w_head;
    logic                r_fault;
    logic                w_unused;

    assign w_accept     = bus.req_valid && bus.req_ready;
    assign w_lane       = bus.req_addr[LB-1:0];
    assign w_size       = 4'd1 << bus.req_funct3[1:0];
    assign w_misaligned = (w_lane & LB'(w_size - 4'd1)) != '0;
    assign w_base       = {bus.req_addr[ADDR_W-1:LB], {LB{1'b0}}};
    assign w_shift      = {{DATA_W{1'b0}}, bus.req_data} << {w_lane, 3'b000};
    assign w_be2        = (2*NB)'(store_be(w_size, 3'(w_lane)));

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_legal = 1'b0;
        case (bus.req_funct3)
            F3_SB, F3_SH, F3_SW: w_legal = 1'b1;
            F3_SD:               w_legal = (NB == 8);
            default:             w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_lo       = '0;
        w_lo.addr  = MAX_ADDR_W'(w_base);
        w_lo.wdata = MAX_DATA_W'(w_shift[DATA_W-1:0]);
        w_lo.be    = MAX_NB'(w_be2[NB-1:0]);
    end

`ifdef STORE_SPLIT_MISALIGNED_EN
    logic         w_cross;
    logic         r_pend;
    store_entry_t w_hi;
    store_entry_t r_pend_entry;

    assign w_cross = (int'(w_lane) + int'(w_size)) > NB;

    always_comb begin
        w_hi       = '0;
        w_hi.addr  = MAX_ADDR_W'(w_base + ADDR_W'(NB));
        w_hi.wdata = MAX_DATA_W'(w_shift[2*DATA_W-1:DATA_W]);
        w_hi.be    = MAX_NB'(w_be2[2*NB-1:NB]);
    end

    // Blocking new requests while the upper half is pending keeps the halves adjacent.
    assign bus.req_ready = (count <= CW'(DEPTH - 2)) && !r_pend;
    assign w_enq         = w_accept && w_legal;
    assign w_fault_d     = w_accept && !w_legal;
    assign w_push        = w_enq || r_pend;
    assign w_push_entry  = r_pend ? r_pend_entry : w_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) r_pend <= 1'b0;
        else        r_pend <= w_enq && w_cross;
    end

    always_ff @(posedge clk) begin
        if (w_enq && w_cross) r_pend_entry <= w_hi;
    end
`else
    assign bus.req_ready = (count < CW'(DEPTH));
    assign w_enq         = w_accept && w_legal && !w_misaligned;
    assign w_fault_d     = w_accept && !(w_legal && !w_misaligned);
    assign w_push        = w_enq;
    assign w_push_entry  = w_lo;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_fault <= 1'b0;
        else        r_fault <= w_fault_d;
    end
    assign misalign_fault = r_fault;

    assign w_pop = bus.mem_valid && bus.mem_ready;

    store_fifo #(
        .T     (store_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign bus.mem_valid = !w_empty;
    assign bus.mem_addr  = w_empty ? '0 : w_head.addr[ADDR_W-1:0];
    assign bus.mem_wdata = w_empty ? '0 : w_head.wdata[DATA_W-1:0];
    assign bus.mem_be    = w_empty ? '0 : w_head.be[NB-1:0];

    // Bits beyond this build's widths, and build-dependent leftovers.
    assign w_unused = ^{w_head, w_shift, w_be2, w_misaligned, w_full};
endmodule
